mole_sequencer: RTL and testbench

Game-round controller for the whack-a-mole datapath. It owns a programmable tick divider and sequences mole appearances: gap, then a mole raised at a pseudo-random hole, then a hit or timeout. It scores hits, deducts lives on misses, and shortens the tick period as the score grows. It sits between the debounced button inputs and the LED/seven-segment display drivers, and it replaces free-running divided clocks with a single-clock tick enable.

---
 rtl/mole_pkg.sv | 23 ++
 rtl/tick_gen.sv | 26 ++
 rtl/mole_sequencer.sv | 155 +++++++++++++++
 tb/tb_mole_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_UP,
        ST_HIT,
        ST_OVER
    } state_t;

    localparam logic [15:0] LFSR_SEED        = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam int          HITS_PER_SPEEDUP = 4;
    localparam int          SCORE_W          = 8;
    localparam int          PERIOD_W         = 27;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable tick-enable divider: one-cycle pulse every period+1 clocks,
// restartable from zero so a caller can align ticks to its own events.
module tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [26:0] period,
    output logic        tick
);

    logic [26:0] cnt;

    assign tick = (cnt == period);

    // The >= guard keeps the counter bounded even if period ever drops below cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt >= period)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 27'd1;
        end
    end

endmodule

// File: rtl/mole_sequencer.sv
// Whack-a-mole round controller: gap / raised mole / hit-or-timeout sequencing,
// scoring, lives and a tick period that shortens as the score grows.
module mole_sequencer
    import mole_pkg::*;
#(
    parameter int N_HOLES   = 8,
    parameter int BASE_DIV  = 12499999,
    parameter int MIN_DIV   = 3124999,
    parameter int STEP_DIV  = 1249999,
    parameter int UP_TICKS  = 6,
    parameter int GAP_TICKS = 2,
    parameter int LIVES     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] btn,
    output logic [N_HOLES-1:0] mole,
    output logic [7:0]         score,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               tick,
    output state_t             state_dbg
);

    localparam int HOLE_W = $clog2(N_HOLES);
    localparam int TCNT_W = 16;

    localparam logic [PERIOD_W-1:0] BASE_P  = PERIOD_W'(BASE_DIV);
    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_DIV);
    localparam logic [PERIOD_W-1:0] STEP_P  = PERIOD_W'(STEP_DIV);
    localparam logic [PERIOD_W-1:0] FLOOR_P = PERIOD_W'(MIN_DIV + STEP_DIV);
    localparam logic [TCNT_W-1:0]   UP_LAST  = TCNT_W'(UP_TICKS - 1);
    localparam logic [TCNT_W-1:0]   GAP_LAST = TCNT_W'(GAP_TICKS - 1);
    localparam logic [SCORE_W-1:0]  SPEEDUP_MASK = SCORE_W'(HITS_PER_SPEEDUP - 1);
    localparam logic [1:0]          LIVES_INIT   = 2'(LIVES);

    state_t               state;
    logic [15:0]          lfsr;
    logic [HOLE_W-1:0]    prev_hole;
    logic [N_HOLES-1:0]   btn_q;
    logic [N_HOLES-1:0]   btn_qq;
    logic [TCNT_W-1:0]    tick_cnt;
    logic [PERIOD_W-1:0]  period;

    logic [N_HOLES-1:0]   edges;
    logic                 hit_ev;
    logic                 miss_ev;
    logic                 gap_done;
    logic                 hit_done;
    logic                 start_ev;
    logic                 clr;
    logic [HOLE_W-1:0]    cand;
    logic [HOLE_W-1:0]    sel_hole;
    logic [SCORE_W-1:0]   score_inc;
    logic [PERIOD_W-1:0]  period_dec;

    assign state_dbg = state;

    tick_gen u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .period (period),
        .tick   (tick)
    );

    // Event decode; the registered edge pair puts a press two clocks from state.
    always_comb begin
        edges      = btn_q & ~btn_qq;
        hit_ev     = (state == ST_UP) && (|(edges & mole));
        miss_ev    = (state == ST_UP) && !hit_ev &&
                     ((|edges) || (tick && (tick_cnt == UP_LAST)));
        gap_done   = (state == ST_GAP) && tick && (tick_cnt == GAP_LAST);
        hit_done   = (state == ST_HIT) && tick;
        start_ev   = ((state == ST_IDLE) || (state == ST_OVER)) && start;
        clr        = hit_ev || miss_ev || gap_done || hit_done || start_ev;
        cand       = lfsr[HOLE_W-1:0];
        sel_hole   = (cand == prev_hole) ? cand + HOLE_W'(1) : cand;
        score_inc  = (score == '1) ? score : score + SCORE_W'(1);
        period_dec = (period >= FLOOR_P) ? period - STEP_P : MIN_P;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mole      <= '0;
            score     <= '0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
            period    <= BASE_P;
            lfsr      <= LFSR_SEED;
            prev_hole <= '0;
            btn_q     <= '0;
            btn_qq    <= '0;
            tick_cnt  <= '0;
        end else begin
            lfsr   <= lfsr_next(lfsr);
            btn_q  <= btn;
            btn_qq <= btn_q;

            if (clr) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + TCNT_W'(1);
            end

            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_ev) begin
                        state     <= ST_GAP;
                        game_over <= 1'b0;
                        score     <= '0;
                        lives     <= LIVES_INIT;
                        period    <= BASE_P;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state     <= ST_UP;
                        mole      <= N_HOLES'(1) << sel_hole;
                        prev_hole <= sel_hole;
                    end
                end
                ST_UP: begin
                    if (hit_ev) begin
                        state <= ST_HIT;
                        mole  <= '0;
                        score <= score_inc;
                        // A saturated score never lands on a multiple, so no speed-up at 255.
                        if ((score_inc & SPEEDUP_MASK) == '0) begin
                            period <= period_dec;
                        end
                    end else if (miss_ev) begin
                        mole  <= '0;
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_HIT: begin
                    if (hit_done) begin
                        state <= ST_GAP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_sequencer.sv
// Randomised bench for mole_sequencer against a cycle-count model of the game rules.
module tb_mole_sequencer;
    import mole_pkg::*;

    localparam int NH    = 8;
    localparam int BASE  = 3;
    localparam int MIN_P = 1;
    localparam int STEP  = 1;
    localparam int UPT   = 4;
    localparam int GAPT  = 2;
    localparam int LIV   = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_GAP  = 1;
    localparam int PH_UP   = 2;
    localparam int PH_HIT  = 3;
    localparam int PH_OVER = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NH-1:0] btn = '0;
    logic [NH-1:0] mole;
    logic [7:0]    score;
    logic [1:0]    lives;
    logic          game_over;
    logic          tick;
    state_t        state_dbg;

    always #5 clk = ~clk;

    mole_sequencer #(
        .N_HOLES(NH), .BASE_DIV(BASE), .MIN_DIV(MIN_P), .STEP_DIV(STEP),
        .UP_TICKS(UPT), .GAP_TICKS(GAPT), .LIVES(LIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn(btn),
        .mole(mole), .score(score), .lives(lives), .game_over(game_over),
        .tick(tick), .state_dbg(state_dbg)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [NH-1:0] rot(input logic [NH-1:0] m);
        return {m[NH-2:0], m[NH-1]};
    endfunction

    // ---------------- behavioural model ----------------
    // Each phase is timed by cycles elapsed since entry; a tick is every (period+1)th cycle.
    int            m_phase = PH_IDLE;
    int            m_el = 0;
    int            m_period = BASE;
    int            m_score = 0;
    int            m_lives = LIV;
    bit            m_go = 1'b0;
    logic [15:0]   m_lfsr = 16'hACE1;
    int            m_prev = 0;
    logic [NH-1:0] m_bq = '0;
    logic [NH-1:0] m_bqq = '0;
    logic [NH-1:0] m_mole = '0;

    task automatic model_reset();
        m_phase = PH_IDLE; m_el = 0; m_period = BASE; m_score = 0; m_lives = LIV;
        m_go = 1'b0; m_lfsr = 16'hACE1; m_prev = 0; m_bq = '0; m_bqq = '0; m_mole = '0;
    endtask

    task automatic model_step();
        logic [NH-1:0] e;
        int per;
        int hole;
        bit moved;
        e = m_bq & ~m_bqq;
        per = m_period + 1;
        moved = 1'b0;
        case (m_phase)
            PH_IDLE, PH_OVER: if (start) begin
                m_phase = PH_GAP; m_score = 0; m_lives = LIV; m_period = BASE;
                m_go = 1'b0; moved = 1'b1;
            end
            PH_GAP: if (m_el == GAPT * per - 1) begin
                hole = int'(m_lfsr) % NH;
                if (hole == m_prev) hole = (hole + 1) % NH;
                m_prev = hole;
                m_mole = '0;
                m_mole[hole] = 1'b1;
                m_phase = PH_UP; moved = 1'b1;
            end
            PH_UP: begin
                if ((e & m_mole) != 0) begin
                    if (m_score < 255) m_score = m_score + 1;
                    if (m_score % 4 == 0)
                        m_period = (m_period - STEP < MIN_P) ? MIN_P : m_period - STEP;
                    m_mole = '0; m_phase = PH_HIT; moved = 1'b1;
                end else if (e != 0 || m_el == UPT * per - 1) begin
                    m_lives = m_lives - 1;
                    m_mole = '0; moved = 1'b1;
                    if (m_lives == 0) begin
                        m_phase = PH_OVER; m_go = 1'b1;
                    end else begin
                        m_phase = PH_GAP;
                    end
                end
            end
            PH_HIT: if (m_el == per - 1) begin
                m_phase = PH_GAP; moved = 1'b1;
            end
            default: ;
        endcase
        m_el = moved ? 0 : m_el + 1;
        m_bqq = m_bq;
        m_bq = btn;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- scoreboard / per-cycle compare ----------------
    logic [NH-1:0] last_mole = '0;
    bit            have_prev = 1'b0;
    int            prev_idx = 0;
    bit            seen [NH];
    int            moles_total = 0;

    always @(negedge rst_n) begin
        have_prev = 1'b0;
        last_mole = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int idx;
            chk("cyc_mole", mole, m_mole);
            chk("cyc_score", score, m_score);
            chk("cyc_lives", lives, m_lives);
            chk("cyc_game_over", game_over, m_go);
            chk("cyc_tick", tick, ((m_el % (m_period + 1)) == m_period));
            chk("mole_onehot0", $onehot0(mole), 1);
            if (mole != 0 && last_mole == 0) begin
                idx = 0;
                for (int i = 0; i < NH; i++) if (mole[i]) idx = i;
                if (have_prev) chk("hole_repeat", (idx == prev_idx), 0);
                seen[idx] = 1'b1;
                prev_idx = idx;
                have_prev = 1'b1;
                moles_total++;
            end
            last_mole = mole;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_mole();
        int n;
        n = 0;
        while (m_mole == 0 && n < 400) begin
            step();
            n++;
        end
        chk("wait_mole_bound", (m_mole != 0), 1);
    endtask

    task automatic press(input logic [NH-1:0] m);
        btn = m;
        step();
        btn = '0;
        step();
    endtask

    task automatic measure_gap(output int g);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 50);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 50);
        g = n;
    endtask

    task automatic wait_mole_clear(output int n);
        n = 0;
        while (mole != 0 && n < 40) begin
            step();
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        int n;
        int moles_r;
        int cyc;
        int act;
        int dly;
        int age;
        int seen_cnt;
        logic [NH-1:0] prev_m;

        for (int i = 0; i < NH; i++) seen[i] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_mole", mole, 0);
        chk("rst_game_over", game_over, 0);
        measure_gap(g);
        chk("idle_tick_spacing", g, 4);

        // Game 1: hit latency and dwell lengths
        start = 1'b1; step(); start = 1'b0;
        wait_mole();
        press(m_mole);
        chk("hit_score", score, 1);
        chk("hit_mole_clear", mole, 0);
        repeat (11) step();
        chk("hit_gap_still_down", mole, 0);
        step();
        chk("hit_gap_next_up", (mole != 0), 1);

        // Speed-up
        for (int i = 0; i < 3; i++) begin wait_mole(); press(m_mole); end
        chk("speed4_score", score, 4);
        chk("speed4_model_period", m_period, 2);
        measure_gap(g);
        chk("speed4_tick_spacing", g, 3);
        for (int i = 0; i < 8; i++) begin wait_mole(); press(m_mole); end
        chk("speed12_score", score, 12);
        chk("speed12_model_period", m_period, 1);
        measure_gap(g);
        chk("speed12_tick_spacing", g, 2);

        // Correct and wrong rising together counts as a hit
        wait_mole();
        press(m_mole | rot(m_mole));
        chk("simul_score", score, 13);
        chk("simul_lives", lives, 3);

        // Three timeouts end the game with the score held
        for (int i = 0; i < 3; i++) begin
            wait_mole();
            wait_mole_clear(n);
            chk("timeout_lives", lives, 2 - i);
        end
        chk("over_flag", game_over, 1);
        chk("over_score", score, 13);
        repeat (10) step();
        chk("over_hold_score", score, 13);
        chk("over_hold_flag", game_over, 1);

        // Game 2: restart from OVER re-initialises everything
        start = 1'b1; step(); start = 1'b0;
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_game_over", game_over, 0);
        wait_mole();
        wait_mole_clear(n);
        chk("timeout_up_cycles", n, 16);
        chk("timeout_lives_3to2", lives, 2);

        // Correct press landing on the final timeout tick is still a hit
        wait_mole();
        repeat (14) step();
        btn = m_mole; step(); btn = '0; step();
        chk("last_tick_hit_score", score, 1);
        chk("last_tick_hit_lives", lives, 2);
        chk("last_tick_hit_mole", mole, 0);

        wait_mole();
        press(rot(m_mole));
        chk("wrong_lives", lives, 1);
        chk("wrong_score", score, 1);
        chk("wrong_mole", mole, 0);

        // Randomised play, restarts and start held during play
        moles_r = 0; cyc = 0; act = 0; dly = 0; age = 0;
        prev_m = m_mole;
        while (moles_r < 100 && cyc < 20000) begin
            btn = '0;
            start = ($urandom_range(0, 9) == 0);
            if ((m_phase == PH_OVER || m_phase == PH_IDLE) && $urandom_range(0, 3) == 0) start = 1'b1;
            if (m_mole != 0 && prev_m == 0) begin
                moles_r++;
                act = $urandom_range(0, 3);
                dly = $urandom_range(0, 6);
                age = 0;
            end
            if (m_mole != 0) begin
                if (age == dly) begin
                    case (act)
                        0: btn = m_mole;
                        1: btn = m_mole | NH'($urandom_range(0, 255));
                        2: btn = rot(m_mole);
                        default: ;
                    endcase
                end
                age++;
            end else if ($urandom_range(0, 4) == 0) begin
                btn = NH'($urandom_range(0, 255));
            end
            prev_m = m_mole;
            step();
            cyc++;
        end
        btn = '0; start = 1'b0;
        chk("random_moles", (moles_r >= 100), 1);
        seen_cnt = 0;
        for (int i = 0; i < NH; i++) if (seen[i]) seen_cnt++;
        chk("all_holes_seen", seen_cnt, NH);

        // Asynchronous reset in the middle of UP
        if (m_phase == PH_OVER || m_phase == PH_IDLE) begin
            start = 1'b1; step(); start = 1'b0;
        end
        wait_mole();
        step();
        chk("pre_reset_mole_up", (mole != 0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_mole", mole, 0);
        chk("async_rst_score", score, 0);
        chk("async_rst_lives", lives, 3);
        chk("async_rst_game_over", game_over, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        measure_gap(g);
        chk("post_rst_tick_spacing", g, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
